exec_sequencer: RTL

Multi-cycle execute stage wrapped around the 8×16-bit register file. It accepts one register-register operation per start strobe and performs these steps:
- reads operand Rn, then Rm, through the file's single combinational read port;
- shifts Rm and applies the ALU;
- latches result and status;
- writes the result back to Rd through the file's write port.

It is both the sole driver of the register file's `readnum`/`writenum`/`write`/`data_in` and the sole consumer of its `data_out`.

---
 rtl/exec_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle execute stage sequencing an external 8x16 register file
//
// Purpose: accepts one register-register op per start strobe, reads Rn then Rm
// through the register file's single read port, shifts Rm, applies the ALU,
// latches C/status and writes C back to Rd.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     request, sampled only in IDLE
//   op, shift, rn, rm, rd     command fields, latched on the accepted start edge
//   wb_en                     1 = write C to rd, 0 = compare-only
//   rf_out                    register file data_out
//   readnum, writenum, write, data_in   register file controls
//   c_out, status             result register and {N, V, Z}
//   busy, done                non-IDLE indicator, one-cycle completion pulse
module exec_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   shift,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [2:0]   rd,
  input  logic         wb_en,
  input  logic [W-1:0] rf_out,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic [W-1:0] data_in,
  output logic [W-1:0] c_out,
  output logic [2:0]   status,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t       state;
  logic [1:0]   op_q, shift_q;
  logic [2:0]   rn_q, rm_q;
  logic         wb_en_q;
  logic [W-1:0] a_q, b_q;

  logic [W-1:0] bs, res;
  logic         v;

  assign data_in = c_out;

  always_comb begin
    bs = b_q;
    case (shift_q)
      2'b01:   bs = {b_q[W-2:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[W-1:1]};
      2'b11:   bs = {b_q[W-1], b_q[W-1:1]};
      default: bs = b_q;
    endcase
  end

  always_comb begin
    res = '0;
    v   = 1'b0;
    case (op_q)
      2'b00: begin
        res = a_q + bs;
        v   = (a_q[W-1] == bs[W-1]) && (res[W-1] != a_q[W-1]);
      end
      2'b01: begin
        res = a_q + ~bs + {{(W-1){1'b0}}, 1'b1};
        v   = (a_q[W-1] != bs[W-1]) && (res[W-1] != a_q[W-1]);
      end
      2'b10:   res = a_q & bs;
      default: res = ~bs;
    endcase
  end

  // All outputs are registered and loaded with the value they must show in
  // the state being entered, so no live input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_out    <= '0;
      status   <= '0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            shift_q  <= shift;
            rn_q     <= rn;
            rm_q     <= rm;
            wb_en_q  <= wb_en;
            readnum  <= rn;
            writenum <= rd;
            busy     <= 1'b1;
            state    <= S_RDA;
          end
        end
        S_RDA: begin
          a_q     <= rf_out;
          readnum <= rm_q;
          state   <= S_RDB;
        end
        S_RDB: begin
          b_q     <= rf_out;
          readnum <= rn_q;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          // Compare-only ops leave C untouched; status always reflects this op.
          if (wb_en_q) c_out <= res;
          status <= {res[W-1], v, (res == '0)};
          write  <= wb_en_q;
          done   <= 1'b1;
          state  <= S_WB;
        end
        S_WB: begin
          write <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
